alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. the execute stage (port 0) and an address/branch helper (port 1).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Only one operation is outstanding at a time.
- Operands are registered before they are driven to the ALU, and the ALU result is registered before it is returned, so the ALU path is isolated between two register stages.

Parameters:
- WIDTH, 32, datapath width of operands and result.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- r0_valid  input  1  port 0 request valid.
- r0_ready  output  1  port 0 request accepted this cycle.
- r0_a  input  WIDTH  port 0 operand a.
- r0_b  input  WIDTH  port 0 operand b.
- r0_ctrl  input  4  port 0 ALU operation code (ALU_OPCODE_* encoding).
- r0_rvalid  output  1  port 0 response valid.
- r0_rready  input  1  port 0 response accepted.
- r0_result  output  WIDTH  port 0 result.
- r0_eq  output  1  port 0 zero flag (result == 0).
- r1_valid, r1_ready, r1_a, r1_b, r1_ctrl, r1_rvalid, r1_rready, r1_result, r1_eq: same as port 0, for port 1.
- alu_a  output  WIDTH  operand a to ALU.
- alu_b  output  WIDTH  operand b to ALU.
- alu_ctrl  output  4  operation select to ALU.
- alu_out  input  WIDTH  ALU result.
- alu_eq  input  1  ALU zero flag.

Behaviour:
- Reset state: IDLE; priority pointer favours port 0.
  - Operand registers (alu_a, alu_b, alu_ctrl) = 0.
  - Result register = 0; eq register = 0; owner = 0.
  - All rN_ready and rN_rvalid = 0.
- FSM states are IDLE, EXEC and RESP.
  - IDLE:
    - Arbitration is combinational. rN_ready = 1 only for the winner among valid requesters; the loser sees ready = 0.
    - Both valid: the port named by the pointer wins. One valid: that port wins regardless of the pointer.
    - On handshake (valid & ready) at edge k: capture a/b/ctrl into the operand registers, record the owner, set the pointer to favour the other port, go to EXEC.
    - No valid: stay in IDLE; operand registers hold their last values.
  - EXEC:
    - No ready asserted.
    - The ALU sees the registered operands. At edge k+1, capture alu_out into the result register and alu_eq into the eq register, then go to RESP.
  - RESP:
    - owner's rvalid = 1; rN_result / rN_eq driven from the result and eq registers.
    - The non-owner's rvalid = 0; its result and eq outputs also carry the registered values but are don't-care.
    - The response is held stable until owner rready = 1. On that edge, go to IDLE.
    - No new request is accepted in RESP.
- Latency and throughput:
  - Request accepted at edge k gives rvalid at edge k+2.
  - Minimum spacing is 3 cycles per operation when rready is held high.
- Protocol rules:
  - rN_ready may depend combinationally on rN_valid.
  - Requesters must hold valid and operands stable until ready is seen.
  - rN_rready outside RESP, or on the non-owner port, is ignored.
- ctrl is passed through unmodified. Undefined codes yield ALU result 0, so eq = 1.
- The pointer updates only on a handshake, not on idle cycles.
- rst asserted mid-operation (EXEC or RESP): abandon the operation with no response. All registers return to reset values immediately (asynchronous).

Test Plan:
- Port 0 alone: r0 ADD a=5, b=7, r0_rready=1 → r0_ready at cycle 0; r0_rvalid at cycle 2 with r0_result=12, r0_eq=0; r1_rvalid stays 0.
- Both valid from reset: r0 SUB 9−9, r1 OR 0xF0|0x0F → r0 granted first; result 0 with eq=1. r1 is then granted with result 0xFF, eq=0. r1 must see ready=0 until IDLE returns.
- Fairness: both ports hold valid continuously for 6 operations → grants alternate 0,1,0,1,0,1.
- Backpressure: r1 SLT a=0xFFFFFFFF, b=1 with r1_rready=0 for 4 cycles → r1_rvalid=1 and r1_result=1 held stable; r0_ready=0 throughout; release on the cycle rready=1.
- Reset mid-op: assert rst while in EXEC → all outputs 0 immediately; no rvalid after release. The next request is serviced with port 0 priority.
- Undefined ctrl=4'hF from port 1 → r1_result=0, r1_eq=1 at cycle 2.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two
// valid/ready requesters; operands and result are registered around the ALU.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [3:0]       r0_ctrl,
    output logic             r0_rvalid,
    input  logic             r0_rready,
    output logic [WIDTH-1:0] r0_result,
    output logic             r0_eq,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [3:0]       r1_ctrl,
    output logic             r1_rvalid,
    input  logic             r1_rready,
    output logic [WIDTH-1:0] r1_result,
    output logic             r1_eq,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_eq
);

    localparam int unsigned CTRL_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [CTRL_W-1:0] ctrl;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;      // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic             r_owner;
    req_t             r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_eq;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_rsp_done;
    req_t             w_req0;
    req_t             w_req1;
    req_t             w_req_sel;

    assign w_req0    = '{a: r0_a, b: r0_b, ctrl: r0_ctrl};
    assign w_req1    = '{a: r1_a, b: r1_b, ctrl: r1_ctrl};
    assign w_req_sel = w_grant1 ? w_req1 : w_req0;

    // Winner among valid requesters; the pointer only breaks ties
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r0_valid && r1_valid) begin
            w_grant0 = ~r_ptr;
            w_grant1 = r_ptr;
        end else begin
            w_grant0 = r0_valid;
            w_grant1 = r1_valid;
        end
    end

    assign w_accept   = (r_state == ST_IDLE) && (r0_valid || r1_valid);
    assign w_rsp_done = (r_state == ST_RESP) && (r_owner ? r1_rready : r0_rready);

    // Next state and handshake outputs; ready is masked while reset is held
    always_comb begin
        w_state_nxt = r_state;
        r0_ready    = 1'b0;
        r1_ready    = 1'b0;
        r0_rvalid   = 1'b0;
        r1_rvalid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                r0_ready = w_grant0 & ~rst;
                r1_ready = w_grant1 & ~rst;
                if (r0_valid || r1_valid) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                r0_rvalid = ~r_owner;
                r1_rvalid = r_owner;
                if (w_rsp_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, owner and pointer update on the request handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
        end else if (w_accept) begin
            r_op    <= w_req_sel;
            r_owner <= w_grant1;
            r_ptr   <= ~w_grant1;
        end
    end

    // ALU result is sampled one cycle after operands are launched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_eq     <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_result <= alu_out;
            r_eq     <= alu_eq;
        end
    end

    assign alu_a     = r_op.a;
    assign alu_b     = r_op.b;
    assign alu_ctrl  = r_op.ctrl;

    assign r0_result = r_result;
    assign r0_eq     = r_eq;
    assign r1_result = r_result;
    assign r1_eq     = r_eq;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU sits on the ALU port,
// expected responses are queued at each grant and retired on response handshakes.
module tb_alu_arbiter;

    localparam int unsigned W = 32;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    logic         clk = 1'b0;
    logic         rst;
    logic         r0_valid, r0_ready, r0_rvalid, r0_rready, r0_eq;
    logic [W-1:0] r0_a, r0_b, r0_result;
    logic [3:0]   r0_ctrl;
    logic         r1_valid, r1_ready, r1_rvalid, r1_rready, r1_eq;
    logic [W-1:0] r1_a, r1_b, r1_result;
    logic [3:0]   r1_ctrl;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_ctrl;
    logic         alu_eq;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   ctrl;
        logic [W-1:0] res;
        logic         eq;
    } op_t;

    typedef struct {
        int           port;
        logic [W-1:0] res;
        logic         eq;
        int           gcyc;
    } exp_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];
    int   grants[$];
    int   cyc = 0;
    int   first_iter;
    logic seen [2];
    int   n_checks = 0;
    int   n_fail = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_ctrl(r0_ctrl), .r0_rvalid(r0_rvalid), .r0_rready(r0_rready),
        .r0_result(r0_result), .r0_eq(r0_eq),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_ctrl(r1_ctrl), .r1_rvalid(r1_rvalid), .r1_rready(r1_rready),
        .r1_result(r1_result), .r1_eq(r1_eq),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_eq(alu_eq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] ctrl);
        case (ctrl)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return W'($signed(a) < $signed(b));
            OP_SLTU: return W'(a < b);
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return W'($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    // Behavioural shared ALU
    always_comb begin
        alu_out = alu_ref(alu_a, alu_b, alu_ctrl);
        alu_eq  = (alu_out == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic add_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] ctrl, input logic [W-1:0] res, input logic eq);
        op_t o;
        o = '{a: a, b: b, ctrl: ctrl, res: res, eq: eq};
        if (p == 0) q0.push_back(o);
        else        q1.push_back(o);
    endtask

    task automatic add_rand(input int p);
        logic [W-1:0] a, b, res;
        logic [3:0]   c;
        a   = $urandom;
        b   = $urandom;
        c   = 4'($urandom_range(0, 15));
        res = alu_ref(a, b, c);
        add_op(p, a, b, c, res, res == '0);
    endtask

    // Drives both request channels from their queues until all ops are granted
    task automatic run_ops(input int budget);
        int   it = 0;
        int   prev = -1;
        logic g0, g1;
        first_iter = -1;
        while ((q0.size() > 0 || q1.size() > 0) && it < budget) begin
            r0_valid = (q0.size() > 0);
            r1_valid = (q1.size() > 0);
            if (q0.size() > 0) begin
                r0_a = q0[0].a; r0_b = q0[0].b; r0_ctrl = q0[0].ctrl;
            end
            if (q1.size() > 0) begin
                r1_a = q1[0].a; r1_b = q1[0].b; r1_ctrl = q1[0].ctrl;
            end
            @(negedge clk);
            g0 = r0_ready;
            g1 = r1_ready;
            if ((g0 && !r0_valid) || (g1 && !r1_valid)) check("ready_without_valid", 32'd1, 32'd0);
            if (g0 && g1) begin
                check("dual_ready", 32'd1, 32'd0);
            end else if (g0 || g1) begin
                if (first_iter < 0) first_iter = it;
                if (prev >= 0) check("grant_gap", 32'(cyc - prev), 32'd3);
                prev = cyc;
                grants.push_back(g1 ? 1 : 0);
                if (g1) sb.push_back('{port: 1, res: q1[0].res, eq: q1[0].eq, gcyc: cyc});
                else    sb.push_back('{port: 0, res: q0[0].res, eq: q0[0].eq, gcyc: cyc});
            end
            @(posedge clk); #1;
            if (g1 && !g0)      q1.delete(0);
            else if (g0 && !g1) q0.delete(0);
            it++;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        if (q0.size() > 0 || q1.size() > 0) begin
            check("grant_timeout", 32'd1, 32'd0);
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > 0) begin
            check("rsp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic mon_port(input int p, input logic rv, input logic rr,
                            input logic [W-1:0] res, input logic eq, input logic orv);
        if (rv) begin
            if (sb.size() == 0) begin
                check("spurious_rvalid", 32'(rv), 32'd0);
            end else begin
                if (!seen[p]) begin
                    seen[p] = 1'b1;
                    check("rsp_port", 32'(p), 32'(sb[0].port));
                    check("rsp_latency", 32'(cyc - sb[0].gcyc), 32'd2);
                    check("other_rvalid", 32'(orv), 32'd0);
                end
                check("rsp_result", res, sb[0].res);
                check("rsp_eq", 32'(eq), 32'(sb[0].eq));
                if (rr) begin
                    sb.delete(0);
                    seen[p] = 1'b0;
                end
            end
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!rst) begin
            mon_port(0, r0_rvalid, r0_rready, r0_result, r0_eq, r1_rvalid);
            mon_port(1, r1_rvalid, r1_rready, r1_result, r1_eq, r0_rvalid);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        seen[0] = 1'b0; seen[1] = 1'b0;
        rst = 1'b1;
        r0_valid = 1'b1; r0_a = 32'h11; r0_b = 32'h22; r0_ctrl = OP_XOR; r0_rready = 1'b1;
        r1_valid = 1'b1; r1_a = 32'h33; r1_b = 32'h44; r1_ctrl = OP_AND; r1_rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_r0_ready", 32'(r0_ready), 32'd0);
        check("rst_r1_ready", 32'(r1_ready), 32'd0);
        check("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        check("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_result", r0_result, 32'd0);
        check("rst_eq", 32'(r0_eq), 32'd0);
        @(negedge clk);
        rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
        @(posedge clk); #1;

        // Both valid from reset: port 0 first, then port 1
        grants.delete();
        add_op(0, 32'd9, 32'd9, OP_SUB, 32'd0, 1'b1);
        add_op(1, 32'hF0, 32'h0F, OP_OR, 32'hFF, 1'b0);
        run_ops(20);
        check("both_grants", 32'(grants.size()), 32'd2);
        if (grants.size() == 2) begin
            check("both_first", 32'(grants[0]), 32'd0);
            check("both_second", 32'(grants[1]), 32'd1);
        end
        drain(10);

        // Fairness with both ports continuously valid
        grants.delete();
        for (int i = 0; i < 3; i++) begin
            add_rand(0);
            add_rand(1);
        end
        run_ops(40);
        check("fair_count", 32'(grants.size()), 32'd6);
        for (int i = 0; i < grants.size(); i++) check("fair_grant", 32'(grants[i]), 32'(i % 2));
        drain(10);

        // Port 0 alone
        add_op(0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0);
        run_ops(10);
        check("p0_ready_cycle0", 32'(first_iter), 32'd0);
        drain(10);

        // Backpressure on port 1 with port 0 requesting meanwhile
        r1_rready = 1'b0;
        add_op(1, 32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd1, 1'b0);
        run_ops(10);
        n = 0;
        while (!r1_rvalid && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_rvalid_seen", 32'(r1_rvalid), 32'd1);
        r0_valid = 1'b1; r0_a = 32'd3; r0_b = 32'd4; r0_ctrl = OP_ADD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_rvalid_held", 32'(r1_rvalid), 32'd1);
            check("bp_result_held", r1_result, 32'd1);
            check("bp_r0_blocked", 32'(r0_ready), 32'd0);
            @(posedge clk); #1;
        end
        r1_rready = 1'b1;
        @(posedge clk); #1;
        r0_valid = 1'b0;
        check("bp_released", 32'(r1_rvalid), 32'd0);
        drain(2);

        // Undefined opcode from port 1
        add_op(1, 32'h1234, 32'h55, 4'hF, 32'd0, 1'b1);
        run_ops(10);
        drain(10);

        // Mixed random traffic
        for (int i = 0; i < 8; i++) add_rand(int'($urandom_range(0, 1)));
        run_ops(60);
        drain(10);

        // Reset while in EXEC; previous port-0 grant would otherwise favour port 1
        add_op(0, 32'd100, 32'd23, OP_ADD, 32'd123, 1'b0);
        run_ops(10);
        r0_valid = 1'b1; r1_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_r0_ready", 32'(r0_ready), 32'd0);
        check("mid_rst_r1_ready", 32'(r1_ready), 32'd0);
        check("mid_rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        check("mid_rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
        check("mid_rst_alu_a", alu_a, 32'd0);
        check("mid_rst_alu_b", alu_b, 32'd0);
        check("mid_rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("mid_rst_r0_result", r0_result, 32'd0);
        check("mid_rst_r1_result", r1_result, 32'd0);
        check("mid_rst_r1_eq", 32'(r1_eq), 32'd0);
        sb.delete();
        seen[0] = 1'b0; seen[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        grants.delete();
        add_op(0, 32'hA, 32'h3, OP_SLL, 32'h50, 1'b0);
        add_op(1, 32'h80, 32'h4, OP_SRL, 32'h8, 1'b0);
        run_ops(20);
        check("post_rst_first", 32'(grants.size() > 0 ? grants[0] : -1), 32'd0);
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
